// File: rtl/dmem_if.sv
// Request/response bundle between the pipeline memory stage and dmem_responder.
// The err signal exists only when DMEM_MISALIGN_CHK_EN is defined.
interface dmem_if;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        stall;
    logic        valid;
`ifdef DMEM_MISALIGN_CHK_EN
    logic        err;
`endif

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, stall, valid
`ifdef DMEM_MISALIGN_CHK_EN
        , input err
`endif
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, stall, valid
`ifdef DMEM_MISALIGN_CHK_EN
        , output err
`endif
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder: IDLE -> BUSY (LATENCY cycles) -> DONE.
// Optional misaligned-access detection is enabled with DMEM_MISALIGN_CHK_EN.
module dmem_responder #(
    parameter int LATENCY = 4,
    parameter int AW      = 10
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_next;
    logic            r_wr;
    logic [AW-1:0]   r_word;
    logic [15:0]     r_wdata;
    logic [15:0]     r_rdata;
    logic [15:0]     r_mem [0:(1<<AW)-1];
    logic            w_accept;
    logic            w_access;
    logic            w_do_write;
    logic            w_do_read;
    logic            w_misalign;

    assign w_accept = (r_state == IDLE) && bus.enable;
    assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.enable) begin
                    w_state_next = BUSY;
                    w_cnt_next   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = DONE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            // The request still on the inputs belongs to the access just completed.
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wr    <= bus.wr;
            r_word  <= bus.addr[AW:1];
            r_wdata <= bus.data_in;
        end
    end

`ifdef DMEM_MISALIGN_CHK_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= bus.addr[0];
        end
    end

    assign w_misalign = r_err;
    assign bus.err    = r_err && (r_state == DONE);

    logic w_unused_addr;
    assign w_unused_addr = ^bus.addr[15:AW+1];
`else
    assign w_misalign = 1'b0;

    // Upper address bits and the byte bit are deliberately dropped (address wrap).
    logic w_unused_addr;
    assign w_unused_addr = ^{bus.addr[15:AW+1], bus.addr[0]};
`endif

    assign w_do_write = w_access && r_wr && !w_misalign;
    assign w_do_read  = w_access && !r_wr;

    // Storage has no reset; an aborted access never reaches w_access.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[r_word] <= r_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 16'h0000;
        end else if (w_do_read) begin
            r_rdata <= w_misalign ? 16'h0000 : r_mem[r_word];
        end
    end

    assign bus.data_out = r_rdata;
    assign bus.stall    = w_accept || (r_state == BUSY);
    assign bus.valid    = (r_state == DONE);
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=4 and LATENCY=1 instances.
module tb_dmem_responder;
    localparam int L4 = 4;

    logic clk = 1'b0;
    logic rst4;
    logic rst1;
    always #5 clk = ~clk;

    dmem_if b4();
    dmem_if b1();

    dmem_responder #(.LATENCY(L4), .AW(10)) dut4 (.clk(clk), .rst(rst4), .bus(b4));
    dmem_responder #(.LATENCY(1),  .AW(10)) dut1 (.clk(clk), .rst(rst1), .bus(b1));

    int total_cnt = 0;
    int pass_cnt  = 0;
    logic [15:0] model [0:1023];
    logic [15:0] exp_q [$];
    logic [15:0] exp1_q [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Issue one access on the LATENCY=4 instance and observe cycles 0..LATENCY+1.
    task automatic access4(input logic w, input logic [15:0] a, input logic [15:0] d);
        int stall_n = 0;
        int valid_at = -1;
        logic [15:0] hold_dout;
        logic [15:0] exp;
        logic exp_err;
        hold_dout = b4.data_out;
        exp_err = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
        exp_err = a[0];
`endif
        b4.enable = 1'b1; b4.wr = w; b4.addr = a; b4.data_in = d;
        if (w) begin
            if (!exp_err) model[a[10:1]] = d;
        end else begin
            exp_q.push_back(exp_err ? 16'h0000 : model[a[10:1]]);
        end
        for (int c = 0; c <= L4 + 1; c++) begin
            #1;
            if (b4.stall) stall_n++;
            if (b4.valid) begin
                valid_at = c;
                total_cnt++;
                if (!w) begin
                    exp = exp_q.pop_front();
                    if (b4.data_out !== exp)
                        $display("FAIL rd_data addr=%h: got %h, required %h", a, b4.data_out, exp);
                    else pass_cnt++;
                end else begin
                    if (b4.data_out !== hold_dout)
                        $display("FAIL dout_hold addr=%h: got %h, required %h", a, b4.data_out, hold_dout);
                    else pass_cnt++;
                end
`ifdef DMEM_MISALIGN_CHK_EN
                total_cnt++;
                if (b4.err !== exp_err)
                    $display("FAIL err addr=%h: got %b, required %b", a, b4.err, exp_err);
                else pass_cnt++;
`endif
            end
            @(posedge clk); #1;
            if (c < L4) begin
                b4.enable = 1'($urandom); b4.wr = 1'($urandom);
                b4.addr = 16'($urandom); b4.data_in = 16'($urandom);
            end else begin
                b4.enable = 1'b0;
            end
        end
        total_cnt++;
        if (stall_n !== L4 + 1)
            $display("FAIL stall_len addr=%h: got %0d, required %0d", a, stall_n, L4 + 1);
        else pass_cnt++;
        total_cnt++;
        if (valid_at !== L4 + 1)
            $display("FAIL valid_cycle addr=%h: got %0d, required %0d", a, valid_at, L4 + 1);
        else pass_cnt++;
        $display("txn L%0d %s addr=%h wdata=%h dout=%h stall_cycles=%0d valid_cycle=%0d",
                 L4, w ? "WR" : "RD", a, d, b4.data_out, stall_n, valid_at);
    endtask

    task automatic test_reset();
        rst4 = 1'b1; rst1 = 1'b1;
        b4.enable = 0; b4.wr = 0; b4.addr = 0; b4.data_in = 0;
        b1.enable = 0; b1.wr = 0; b1.addr = 0; b1.data_in = 0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({b4.stall, b4.valid, b4.data_out} !== 18'h0)
            $display("FAIL reset4: got stall=%b valid=%b dout=%h, required 0 0 0000", b4.stall, b4.valid, b4.data_out);
        else pass_cnt++;
        total_cnt++;
        if ({b1.stall, b1.valid, b1.data_out} !== 18'h0)
            $display("FAIL reset1: got stall=%b valid=%b dout=%h, required 0 0 0000", b1.stall, b1.valid, b1.data_out);
        else pass_cnt++;
        rst4 = 1'b0; rst1 = 1'b0;
        @(posedge clk); #1;
        $display("txn reset released");
    endtask

    task automatic test_write_read();
        access4(1'b1, 16'h0010, 16'hBEEF);
        access4(1'b0, 16'h0010, 16'h0000);
        total_cnt++;
        if (b4.data_out !== 16'hBEEF)
            $display("FAIL write_read: got %h, required BEEF", b4.data_out);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        access4(1'b1, 16'h0802, 16'h1234);
        access4(1'b0, 16'h0002, 16'h0000);
        total_cnt++;
        if (b4.data_out !== 16'h1234)
            $display("FAIL wrap: got %h, required 1234", b4.data_out);
        else pass_cnt++;
`ifndef DMEM_MISALIGN_CHK_EN
        access4(1'b1, 16'h0041, 16'hC0DE);
        access4(1'b0, 16'h0040, 16'h0000);
        total_cnt++;
        if (b4.data_out !== 16'hC0DE)
            $display("FAIL byte_bit: got %h, required C0DE", b4.data_out);
        else pass_cnt++;
`endif
    endtask

    task automatic test_patterns();
        logic [15:0] addrs [4] = '{16'h0100, 16'h07FE, 16'h0000, 16'h0456};
        logic [15:0] datas [4] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h5A5A};
        for (int i = 0; i < 4; i++) access4(1'b1, addrs[i], datas[i]);
        for (int i = 3; i >= 0; i--) access4(1'b0, addrs[i], 16'h0000);
    endtask

    task automatic test_reset_mid_access();
        int early_valid = 0;
        access4(1'b1, 16'h0020, 16'h1111);
        b4.enable = 1'b1; b4.wr = 1'b1; b4.addr = 16'h0020; b4.data_in = 16'hAAAA;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (b4.valid) early_valid++;
            if (c < 2) begin
                @(posedge clk); #1;
                b4.enable = 1'b0;
            end
        end
        rst4 = 1'b1;
        #1;
        total_cnt++;
        if (early_valid !== 0)
            $display("FAIL mid_rst_valid: got %0d pulses, required 0", early_valid);
        else pass_cnt++;
        total_cnt++;
        if ({b4.stall, b4.valid, b4.data_out} !== 18'h0)
            $display("FAIL mid_rst_state: got stall=%b valid=%b dout=%h, required 0 0 0000", b4.stall, b4.valid, b4.data_out);
        else pass_cnt++;
        @(posedge clk); #1;
        rst4 = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (b4.valid !== 1'b0)
            $display("FAIL post_rst_valid: got %b, required 0", b4.valid);
        else pass_cnt++;
        $display("txn L%0d WR addr=0020 wdata=AAAA aborted by reset", L4);
        access4(1'b0, 16'h0020, 16'h0000);
    endtask

    task automatic test_held_enable();
        int vcount = 0;
        int first_v = -1;
        int second_v = -1;
        logic accept_stall = 1'b0;
        logic [15:0] exp;
        b4.enable = 1'b1; b4.wr = 1'b0; b4.addr = 16'h0010; b4.data_in = 16'h0;
        exp_q.push_back(model[10'h008]);
        exp_q.push_back(model[10'h008]);
        for (int c = 0; c <= 2 * L4 + 3; c++) begin
            #1;
            if (c == L4 + 2) accept_stall = b4.stall;
            if (b4.valid) begin
                vcount++;
                if (first_v < 0) first_v = c; else second_v = c;
                exp = exp_q.pop_front();
                total_cnt++;
                if (b4.data_out !== exp)
                    $display("FAIL held_data: got %h, required %h", b4.data_out, exp);
                else pass_cnt++;
            end
            @(posedge clk); #1;
            if (c == 2 * L4 + 3) b4.enable = 1'b0;
        end
        #1;
        total_cnt++;
        if (vcount !== 2 || first_v !== L4 + 1 || second_v !== 2 * L4 + 3)
            $display("FAIL held_valid: got count=%0d at %0d,%0d, required 2 at %0d,%0d",
                     vcount, first_v, second_v, L4 + 1, 2 * L4 + 3);
        else pass_cnt++;
        total_cnt++;
        if (accept_stall !== 1'b1)
            $display("FAIL held_reaccept_stall: got %b, required 1", accept_stall);
        else pass_cnt++;
        total_cnt++;
        if ({b4.stall, b4.valid} !== 2'b00)
            $display("FAIL held_idle: got stall=%b valid=%b, required 0 0", b4.stall, b4.valid);
        else pass_cnt++;
        $display("txn L%0d held-enable RD x2 valids=%0d", L4, vcount);
    endtask

    task automatic access1(input logic w, input logic [15:0] a, input logic [15:0] d);
        int stall_n = 0;
        int valid_at = -1;
        logic [15:0] exp;
        b1.enable = 1'b1; b1.wr = w; b1.addr = a; b1.data_in = d;
        if (!w) exp1_q.push_back(16'h7E57);
        for (int c = 0; c <= 2; c++) begin
            #1;
            if (b1.stall) stall_n++;
            if (b1.valid) begin
                valid_at = c;
                if (!w) begin
                    exp = exp1_q.pop_front();
                    total_cnt++;
                    if (b1.data_out !== exp)
                        $display("FAIL lat1_data: got %h, required %h", b1.data_out, exp);
                    else pass_cnt++;
                end
            end
            @(posedge clk); #1;
            b1.enable = 1'b0;
        end
        total_cnt++;
        if (stall_n !== 2 || valid_at !== 2)
            $display("FAIL lat1_timing: got stall=%0d valid_at=%0d, required 2 and 2", stall_n, valid_at);
        else pass_cnt++;
        $display("txn L1 %s addr=%h dout=%h stall_cycles=%0d valid_cycle=%0d",
                 w ? "WR" : "RD", a, b1.data_out, stall_n, valid_at);
    endtask

    task automatic test_latency1();
        access1(1'b1, 16'h0004, 16'h7E57);
        access1(1'b0, 16'h0004, 16'h0000);
    endtask

`ifdef DMEM_MISALIGN_CHK_EN
    task automatic test_misalign();
        access4(1'b1, 16'h0030, 16'h3333);
        access4(1'b1, 16'h0031, 16'h5555);
        access4(1'b0, 16'h0030, 16'h0000);
        total_cnt++;
        if (b4.data_out !== 16'h3333)
            $display("FAIL misalign_store: got %h, required 3333", b4.data_out);
        else pass_cnt++;
        access4(1'b0, 16'h0031, 16'h0000);
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_patterns();
        test_reset_mid_access();
        test_held_enable();
        test_latency1();
`ifdef DMEM_MISALIGN_CHK_EN
        test_misalign();
`endif
        total_cnt++;
        if (exp_q.size() + exp1_q.size() !== 0)
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size() + exp1_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter LATENCY, default 4, meaning the number of BUSY cycles per access (legal range 1..15).
REQ-002 Parameter AW, default 10, meaning log2 of the word depth of the storage array.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 enable  input  1  request valid from the pipeline memory stage (MemOp).
REQ-006 wr  input  1  request type: 1 = write, 0 = read (MemWrite).
REQ-007 addr  input  16  byte address; word index = addr[AW:1].
REQ-008 data_in  input  16  write data.
REQ-009 data_out  output  16  registered read data.
REQ-010 stall  output  1  freezes the requesting pipeline while high.
REQ-011 valid  output  1  one-cycle completion pulse for both reads and writes.

Function
REQ-012 The block SHALL implement the FSM states IDLE, BUSY and DONE, plus a 4-bit down-counter cnt.
REQ-013 In IDLE with enable=1, the block SHALL latch addr, wr and data_in, load cnt=LATENCY-1, and go to BUSY.
REQ-014 In IDLE with enable=0, the block SHALL remain in IDLE with no storage or data_out change.
REQ-015 In BUSY with cnt!=0, the block SHALL decrement cnt; inputs are ignored.
REQ-016 In BUSY with cnt==0, the block SHALL perform the latched access and go to DONE: a write updates mem[word]; a read loads data_out from mem[word].
REQ-017 In DONE, the block SHALL go to IDLE on the next edge regardless of enable, because the request still present in DONE is the completed one.
REQ-018 stall SHALL be combinational: high when (IDLE and enable) or BUSY; low in DONE and in idle IDLE.
REQ-019 valid SHALL be high only in DONE.
REQ-020 Timing: request accepted in cycle 0; BUSY in cycles 1..LATENCY; valid in cycle LATENCY+1; stall high in cycles 0..LATENCY.
REQ-021 Back-to-back requests SHALL be accepted no earlier than the cycle after DONE (IDLE re-entry); the minimum request spacing is LATENCY+2 cycles.
REQ-022 Address bits above bit AW and addr[0] SHALL be ignored, so addresses wrap modulo 2^(AW+1) bytes.
REQ-023 data_out SHALL hold its last read value across writes and idle cycles.
REQ-024 Input changes during BUSY SHALL NOT affect the in-flight access.

Reset
REQ-025 On rst, the block SHALL immediately enter IDLE, with cnt=0, data_out=16'h0000 and valid=0; stall then follows REQ-018.
REQ-026 A reset during BUSY SHALL abort the access: no storage write occurs and no valid pulse is issued.
REQ-027 Storage contents SHALL NOT be altered by rst.

Configuration
REQ-028 With DMEM_MISALIGN_CHK_EN defined, the block SHALL add output err (1 bit): it is latched on accept as addr[0], cleared by rst, and reported alongside valid; a misaligned write SHALL NOT update storage, and a misaligned read SHALL return 16'h0000.
REQ-029 Without DMEM_MISALIGN_CHK_EN, the err port SHALL be absent and addr[0] ignored per REQ-022.

Verification
REQ-030 Write-then-read: with LATENCY=4, write addr=16'h0010, data_in=16'hBEEF; then read 16'h0010 -> stall high for 5 cycles, valid in cycle 5 of each access, data_out=16'hBEEF after the read.
REQ-031 Wrap: with AW=10, write 16'h0802 with 16'h1234, then read 16'h0002 -> data_out=16'h1234.
REQ-032 Reset mid-access: write 16'h0020 with 16'hAAAA; assert rst in BUSY with cnt=2; then read 16'h0020 -> old contents returned, and no valid pulse before reset.
REQ-033 Held enable: keep enable=1 continuously across two reads -> exactly one valid per LATENCY+2 cycles, and DONE never re-accepts.
REQ-034 LATENCY=1: a single read -> stall high for 2 cycles and valid in cycle 2.
REQ-035 With DMEM_MISALIGN_CHK_EN defined: write 16'h0031 with 16'h5555 -> err=1 with valid; a subsequent read of 16'h0030 -> its prior contents are unchanged.
